// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - retirement observation bus from the MEM/WB stage
interface commit_trace_buffer_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              i_wb_vld;
    logic [PC_W-1:0]   i_wb_pc;
    logic [INST_W-1:0] i_wb_inst;
    logic              i_wb_ctrl;
    logic              i_wb_mispred;

    modport master (
        output i_wb_vld, i_wb_pc, i_wb_inst, i_wb_ctrl, i_wb_mispred
    );

    modport slave (
        input i_wb_vld, i_wb_pc, i_wb_inst, i_wb_ctrl, i_wb_mispred
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retirement trace buffer with PC trigger and perf counters
module commit_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    commit_trace_buffer_if.slave wb,
    input  logic                 i_arm,
    input  logic                 i_trig_en,
    input  logic [PC_W-1:0]      i_trig_pc,
    input  logic [AW:0]          i_post_cnt,
    input  logic [AW-1:0]        i_rd_idx,
    output logic [PC_W-1:0]      o_rd_pc,
    output logic [INST_W-1:0]    o_rd_inst,
    output logic [1:0]           o_rd_flags,
    output logic [AW:0]          o_count,
    output logic [1:0]           o_state,
    output logic [CNT_W-1:0]     o_cycles,
    output logic [CNT_W-1:0]     o_retired,
    output logic [CNT_W-1:0]     o_ctrl_cnt,
    output logic [CNT_W-1:0]     o_mispred_cnt
);
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMED     = 2'b01,
        TRIGGERED = 2'b10,
        DONE      = 2'b11
    } state_t;

    localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]      ONE_AW  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       remaining;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [1:0]        flag_mem [DEPTH];

    logic          active;
    logic          capture;
    logic [AW-1:0] oldest;
    logic [AW-1:0] rd_slot;

    // Arm has priority, so a retire in the arm cycle is neither captured nor counted.
    assign active  = ((state == ARMED) || (state == TRIGGERED)) && !i_arm;
    assign capture = active && wb.i_wb_vld;
    assign oldest  = (o_count == FULL) ? wr_ptr : '0;
    assign rd_slot = oldest + i_rd_idx;
    assign o_state = state;

    // Capture FSM: pointer, fill level, post-trigger window and saturating counters.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            o_count       <= '0;
            remaining     <= '0;
            o_cycles      <= '0;
            o_retired     <= '0;
            o_ctrl_cnt    <= '0;
            o_mispred_cnt <= '0;
        end else if (i_arm) begin
            state         <= ARMED;
            wr_ptr        <= '0;
            o_count       <= '0;
            remaining     <= '0;
            o_cycles      <= '0;
            o_retired     <= '0;
            o_ctrl_cnt    <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (active && o_cycles != CNT_MAX) begin
                o_cycles <= o_cycles + CNT_ONE;
            end
            if (capture) begin
                if (o_retired != CNT_MAX) begin
                    o_retired <= o_retired + CNT_ONE;
                end
                if (wb.i_wb_ctrl && o_ctrl_cnt != CNT_MAX) begin
                    o_ctrl_cnt <= o_ctrl_cnt + CNT_ONE;
                end
                if (wb.i_wb_mispred && o_mispred_cnt != CNT_MAX) begin
                    o_mispred_cnt <= o_mispred_cnt + CNT_ONE;
                end
                wr_ptr <= wr_ptr + PTR_ONE;
                if (o_count != FULL) begin
                    o_count <= o_count + ONE_AW;
                end
                if (state == ARMED) begin
                    if (i_trig_en && wb.i_wb_pc == i_trig_pc) begin
                        remaining <= i_post_cnt;
                        state     <= (i_post_cnt == '0) ? DONE : TRIGGERED;
                    end
                end else begin
                    // Remaining is at least one here; the retire that empties it closes the window.
                    remaining <= remaining - ONE_AW;
                    if (remaining == ONE_AW) begin
                        state <= DONE;
                    end
                end
            end
        end
    end

    // Trace storage write; contents are cleared by reset so stale traces never leak out.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                flag_mem[i] <= '0;
            end
        end else if (capture) begin
            pc_mem[wr_ptr]   <= wb.i_wb_pc;
            inst_mem[wr_ptr] <= wb.i_wb_inst;
            flag_mem[wr_ptr] <= {wb.i_wb_ctrl, wb.i_wb_mispred};
        end
    end

    // Registered readout relative to the oldest entry; indices past the fill level read zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rd_pc    <= '0;
            o_rd_inst  <= '0;
            o_rd_flags <= '0;
        end else if ({1'b0, i_rd_idx} >= o_count) begin
            o_rd_pc    <= '0;
            o_rd_inst  <= '0;
            o_rd_flags <= '0;
        end else begin
            o_rd_pc    <= pc_mem[rd_slot];
            o_rd_inst  <= inst_mem[rd_slot];
            o_rd_flags <= flag_mem[rd_slot];
        end
    end
endmodule
